wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 20 ++
 rtl/wb_stage_scoreboard.sv | 52 +++++
 rtl/wb_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Shared CPU definitions used by the writeback stage: widths, register
// count and the write-back source select encodings.
package wb_stage_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_e;

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    return sgn ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
  endfunction

endpackage

// File: rtl/wb_stage_scoreboard.sv
// Per-register pending-write counters (2-bit saturating, r1..r15) and the
// decode stall that results from them.
module wb_scoreboard
  import wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              chk_en1,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic              chk_en2,
  input  logic [REG_AW-1:0] chk_rs2,
  output logic              stall
);

  logic [1:0] cnt     [1:NUM_REGS-1];
  logic [1:0] cnt_all [NUM_REGS];
  logic       iss_sat;
  logic       inc_ok;

  // r0 is never tracked, so it reads as zero pending.
  always_comb begin
    cnt_all[0] = 2'd0;
    for (int i = 1; i < NUM_REGS; i++) cnt_all[i] = cnt[i];
  end

  assign iss_sat = (cnt_all[iss_rd] == 2'd3);
  assign inc_ok  = iss_valid && (iss_rd != '0) && !iss_sat;

  assign stall = (chk_en1 && (cnt_all[chk_rs1] != 2'd0)) ||
                 (chk_en2 && (cnt_all[chk_rs2] != 2'd0)) ||
                 (iss_valid && iss_sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) cnt[i] <= 2'd0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (inc_ok && (iss_rd == REG_AW'(i)) && !(dec_valid && (dec_rd == REG_AW'(i)))) begin
          cnt[i] <= cnt[i] + 2'd1;
        end else if (dec_valid && (dec_rd == REG_AW'(i)) &&
                     !(inc_ok && (iss_rd == REG_AW'(i))) && (cnt[i] != 2'd0)) begin
          cnt[i] <= cnt[i] - 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one result register formatted at capture, committed to
// the register file (and bypass) when not held, plus pending-write tracking.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wb_en,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_ld_byte,
  input  logic              in_ld_signed,
  input  logic              in_byte_hi,
  input  logic              hold,
  output logic              reg_write,
  output logic [REG_AW-1:0] rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              chk_en1,
  input  logic              chk_en2,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  output logic              stall
);

  logic              full;
  logic              wb_en_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] wb_data;
  logic [7:0]        ld_byte;
  logic              capture;
  logic              commit;

  // A new capture may overwrite the entry that commits on the same edge.
  assign in_ready  = !full || !hold;
  assign capture   = in_valid && in_ready;
  assign commit    = full && !hold;
  assign reg_write = commit && wb_en_q && (rd_q != '0);

  assign rd        = rd_q;
  assign rd_data   = data_q;
  assign fwd_valid = reg_write;
  assign fwd_rd    = rd_q;
  assign fwd_data  = data_q;

  assign ld_byte = in_byte_hi ? in_mem[15:8] : in_mem[7:0];

  always_comb begin
    wb_data = in_alu;
    case (wb_sel_e'(in_wb_sel))
      WB_ALU:  wb_data = in_alu;
      WB_LOAD: wb_data = in_ld_byte ? ext_byte(ld_byte, in_ld_signed) : in_mem;
      WB_LINK: wb_data = in_pc + DATA_W'(2);
      WB_IMM:  wb_data = in_imm;
      default: wb_data = in_alu;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 1'b0;
      wb_en_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      if (capture) begin
        full    <= 1'b1;
        wb_en_q <= in_wb_en;
        rd_q    <= in_rd;
        data_q  <= wb_data;
      end else if (commit) begin
        full    <= 1'b0;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .dec_valid (reg_write),
    .dec_rd    (rd_q),
    .chk_en1   (chk_en1),
    .chk_rs1   (chk_rs1),
    .chk_en2   (chk_en2),
    .chk_rs2   (chk_rs2),
    .stall     (stall)
  );

endmodule
